// File: rtl/mult4u_ctrl_pkg.sv
// Shared types and mod-3 residue helpers for the shared 4x4 multiplier controller.
// A residue of 2'b11 never occurs; every function returns 0, 1 or 2.
package mult4u_ctrl_pkg;

    localparam int OPW = 4;
    localparam int PW  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Reduces a small sum (0..7) to its residue mod 3.
    function automatic logic [1:0] res3_fold(input logic [2:0] s);
        logic [1:0] r;
        case (s)
            3'd0, 3'd3, 3'd6: r = 2'd0;
            3'd1, 3'd4, 3'd7: r = 2'd1;
            default:          r = 2'd2;
        endcase
        return r;
    endfunction

    // 4 == 1 (mod 3), so the base-4 digits can simply be summed.
    function automatic logic [1:0] res3_4(input logic [OPW-1:0] x);
        return res3_fold(3'(x[3:2]) + 3'(x[1:0]));
    endfunction

    // 16 == 1 (mod 3), so the two nibble residues can be summed.
    function automatic logic [1:0] res3_8(input logic [PW-1:0] x);
        return res3_fold(3'(res3_4(x[7:4])) + 3'(res3_4(x[3:0])));
    endfunction

    function automatic logic [1:0] res3_mul(input logic [1:0] ra, input logic [1:0] rb);
        return res3_fold(3'(ra) * 3'(rb));
    endfunction

endpackage

// File: rtl/mult4u_core.sv
// Combinational 4x4 unsigned multiplier core; stands in for the selected
// gate-level variant and keeps its A, B, O pin order.
module mult4u_core
    import mult4u_ctrl_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  p
);

    assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/mult4u_arb_ctrl.sv
// Round-robin arbiter and sequencer sharing one 4x4 multiplier core, with a
// mod-3 residue check on every product and bounded re-execution on mismatch.
module mult4u_arb_ctrl
    import mult4u_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_id,
    output logic [7:0]             rsp_product,
    output logic                   rsp_err,
    input  logic                   rsp_ready,
    input  logic [7:0]             fault_inj,
    output logic [7:0]             err_cnt,
    output logic [1:0]             fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready, and a source keeps valid
    // and its data stable until that edge.

    state_t          state;
    state_t          state_next;

    logic [1:0]      rr_ptr;
    logic [1:0]      id_q;
    logic [OPW-1:0]  a_q;
    logic [OPW-1:0]  b_q;
    logic [PW-1:0]   prod_q;
    logic [2:0]      attempt_q;
    logic            err_q;

    logic [3:0]      valid_pad;
    logic [15:0]     a_pad;
    logic [15:0]     b_pad;
    logic [2:0]      scan;
    logic            win_found;
    logic [1:0]      win_id;
    logic [PW-1:0]   core_p;
    logic            residue_ok;
    logic            retry_left;
    logic [2:0]      ptr_inc;
    logic [1:0]      next_ptr;

    // Padding to four lanes lets a 2-bit requester index select directly.
    assign valid_pad = 4'(req_valid);
    assign a_pad     = 16'(req_a);
    assign b_pad     = 16'(req_b);

    always_comb begin
        scan      = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + 3'(k);
            if (scan >= 3'(NUM_REQ)) begin
                scan = scan - 3'(NUM_REQ);
            end
            if (!win_found && valid_pad[scan[1:0]]) begin
                win_found = 1'b1;
                win_id    = scan[1:0];
            end
        end
    end

    mult4u_core u_core (
        .a (a_q),
        .b (b_q),
        .p (core_p)
    );

    // Faults that shift the product by a multiple of 3 pass this check.
    assign residue_ok = (res3_8(prod_q) == res3_mul(res3_4(a_q), res3_4(b_q)));
    assign retry_left = (attempt_q < 3'(MAX_RETRY));

    assign ptr_inc  = {1'b0, id_q} + 3'd1;
    assign next_ptr = (ptr_inc >= 3'(NUM_REQ)) ? 2'd0 : ptr_inc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (residue_ok) begin
                    state_next = RESP;
                end else if (retry_left) begin
                    state_next = ISSUE;
                end else begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant is gated by rst so every output reads 0 while reset is applied.
    always_comb begin
        req_ready   = '0;
        rsp_valid   = 1'b0;
        rsp_id      = '0;
        rsp_product = '0;
        rsp_err     = 1'b0;
        case (state)
            IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = win_found && !rst && (win_id == 2'(i));
                end
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_id      = id_q;
                rsp_product = prod_q;
                rsp_err     = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
            attempt_q <= '0;
            err_q     <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        a_q       <= a_pad[{win_id, 2'b00} +: 4];
                        b_q       <= b_pad[{win_id, 2'b00} +: 4];
                        id_q      <= win_id;
                        attempt_q <= '0;
                        err_q     <= 1'b0;
                    end
                end
                ISSUE: begin
                    prod_q <= core_p ^ fault_inj;
                end
                CHECK: begin
                    if (!residue_ok) begin
                        if (retry_left) begin
                            attempt_q <= attempt_q + 3'd1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= next_ptr;
                        if (err_q && (err_cnt != 8'hFF)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_mult4u_arb_ctrl.sv
// Scenario bench for mult4u_arb_ctrl with two requesters and two retries.
module tb_mult4u_arb_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_ready;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [7:0] rsp_product;
  logic       rsp_err;
  logic       rsp_ready;
  logic [7:0] fault_inj;
  logic [7:0] err_cnt;
  logic [1:0] fsm_state;

  int tests = 0;
  int fails = 0;
  logic [9:0] exp_q[$];

  mult4u_arb_ctrl #(.NUM_REQ(2), .MAX_RETRY(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .rsp_ready   (rsp_ready),
    .fault_inj   (fault_inj),
    .err_cnt     (err_cnt),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    fault_inj = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // driver tasks
  task automatic accept(input logic [0:0] id, input logic [3:0] a, input logic [3:0] b,
                        output bit ok);
    ok = 1'b0;
    req_valid[id] = 1'b1;
    req_a[{id, 2'b00} +: 4] = a;
    req_b[{id, 2'b00} +: 4] = b;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int lat, output bit ok);
    lat = start;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    req_a = 8'h35;
    req_b = 8'h53;
    rsp_ready = 1'b1;
    fault_inj = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if ({rsp_id, rsp_product, rsp_err} !== 11'd0) begin fails++; $display("FAIL reset_rsp_data got id=%0d p=%h err=%b want 0", rsp_id, rsp_product, rsp_err); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    tests++; if (fsm_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", fsm_state); end
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int lat;
    logic [9:0] e;
    apply_reset();
    accept(1'b0, 4'd3, 4'd5, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_grant got timeout want grant"); end
    exp_q.push_back({2'd0, 8'h0F});
    wait_rsp(1, lat, ok);
    tests++; if (!ok || lat != 3) begin fails++; $display("FAIL single_latency got %0d (ok=%0d) want 3", lat, ok); end
    e = exp_q.pop_front();
    tests++; if ({rsp_id, rsp_product} !== e || rsp_err !== 1'b0) begin fails++; $display("FAIL single_rsp got id=%0d p=%h err=%b want id=%0d p=%h err=0", rsp_id, rsp_product, rsp_err, e[9:8], e[7:0]); end
    finish_rsp();
  endtask

  task automatic test_fairness();
    logic [0:0] model_ptr;
    logic [9:0] e;
    int got;
    apply_reset();
    req_a = {4'd2, 4'd15};
    req_b = {4'd7, 4'd15};
    req_valid = 2'b11;
    model_ptr = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        tests++; if (req_ready !== (2'b01 << model_ptr)) begin fails++; $display("FAIL fair_grant got %b want %b", req_ready, 2'b01 << model_ptr); end
        exp_q.push_back({1'b0, model_ptr, model_ptr ? 8'h0E : 8'hE1});
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++; $display("FAIL fair_unexpected_rsp got id=%0d want none", rsp_id);
        end else begin
          e = exp_q.pop_front();
          tests++; if ({rsp_id, rsp_product} !== e || rsp_err !== 1'b0) begin fails++; $display("FAIL fair_rsp got id=%0d p=%h err=%b want id=%0d p=%h err=0", rsp_id, rsp_product, rsp_err, e[9:8], e[7:0]); end
          model_ptr = ~e[8];
        end
        got++;
        if (got == 4) begin
          req_valid = '0;
          break;
        end
      end
    end
    req_valid = '0;
    tests++; if (got != 4) begin fails++; $display("FAIL fair_count got %0d want 4", got); end
    @(posedge clk);
    #1;
    exp_q.delete();
  endtask

  task automatic test_persistent_fault();
    bit ok;
    int lat;
    apply_reset();
    fault_inj = 8'h01;
    accept(1'b0, 4'd3, 4'd5, ok);
    wait_rsp(1, lat, ok);
    tests++; if (!ok || lat != 7) begin fails++; $display("FAIL pfault_latency got %0d (ok=%0d) want 7", lat, ok); end
    tests++; if (rsp_product !== 8'h0E || rsp_err !== 1'b1 || rsp_id !== 2'd0) begin fails++; $display("FAIL pfault_rsp got id=%0d p=%h err=%b want id=0 p=0e err=1", rsp_id, rsp_product, rsp_err); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL pfault_cnt_before got %0d want 0", err_cnt); end
    finish_rsp();
    fault_inj = '0;
    @(negedge clk);
    tests++; if (err_cnt !== 8'd1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL pfault_cnt_after got cnt=%0d valid=%b want cnt=1 valid=0", err_cnt, rsp_valid); end
  endtask

  task automatic test_transient_fault();
    bit ok;
    int lat;
    apply_reset();
    fault_inj = 8'h01;
    accept(1'b1, 4'd3, 4'd5, ok);
    @(posedge clk);
    #1 fault_inj = '0;
    wait_rsp(2, lat, ok);
    tests++; if (!ok || lat != 5) begin fails++; $display("FAIL tfault_latency got %0d (ok=%0d) want 5", lat, ok); end
    tests++; if (rsp_product !== 8'h0F || rsp_err !== 1'b0 || rsp_id !== 2'd1) begin fails++; $display("FAIL tfault_rsp got id=%0d p=%h err=%b want id=1 p=0f err=0", rsp_id, rsp_product, rsp_err); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad;
    int lat;
    apply_reset();
    rsp_ready = 1'b0;
    accept(1'b0, 4'd9, 4'd9, ok);
    req_a[7:4] = 4'd4;
    req_b[7:4] = 4'd6;
    req_valid[1] = 1'b1;
    wait_rsp(1, lat, ok);
    tests++; if (!ok || rsp_product !== 8'h51 || rsp_id !== 2'd0) begin fails++; $display("FAIL bp_first_rsp got id=%0d p=%h ok=%0d want id=0 p=51", rsp_id, rsp_product, ok); end
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_product !== 8'h51 || rsp_id !== 2'd0 || rsp_err !== 1'b0 || req_ready !== 2'b00) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL bp_hold got valid=%b p=%h ready=%b want valid=1 p=51 ready=00", rsp_valid, rsp_product, req_ready); end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_next_grant got %b want 10", req_ready); end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_rsp(1, lat, ok);
    tests++; if (!ok || lat != 3 || rsp_product !== 8'h18 || rsp_id !== 2'd1) begin fails++; $display("FAIL bp_second_rsp got id=%0d p=%h lat=%0d want id=1 p=18 lat=3", rsp_id, rsp_product, lat); end
    finish_rsp();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int lat;
    apply_reset();
    accept(1'b0, 4'd7, 4'd7, ok);
    @(posedge clk);
    #1;
    tests++; if (fsm_state !== 2'd2) begin fails++; $display("FAIL rmid_in_check got %0d want 2", fsm_state); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if ({req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, err_cnt, fsm_state} !== 24'd0) begin fails++; $display("FAIL rmid_outputs got ready=%b valid=%b id=%0d p=%h err=%b cnt=%0d st=%0d want all 0", req_ready, rsp_valid, rsp_id, rsp_product, rsp_err, err_cnt, fsm_state); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL rmid_dropped got rsp_valid=1 want 0"); end
    accept(1'b1, 4'd6, 4'd5, ok);
    wait_rsp(1, lat, ok);
    tests++; if (!ok || lat != 3 || rsp_product !== 8'h1E || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin fails++; $display("FAIL rmid_fresh got id=%0d p=%h err=%b lat=%0d want id=1 p=1e err=0 lat=3", rsp_id, rsp_product, rsp_err, lat); end
    finish_rsp();
  endtask

  task automatic test_random();
    bit ok;
    int lat;
    logic [0:0] id;
    logic [3:0] a;
    logic [3:0] b;
    logic [9:0] e;
    apply_reset();
    for (int n = 0; n < 12; n++) begin
      id = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      rsp_ready = 1'($urandom_range(0, 1));
      accept(id, a, b, ok);
      exp_q.push_back({1'b0, id, {4'b0000, a} * {4'b0000, b}});
      wait_rsp(1, lat, ok);
      e = exp_q.pop_front();
      tests++; if (!ok || lat != 3 || {rsp_id, rsp_product} !== e || rsp_err !== 1'b0) begin fails++; $display("FAIL rand_rsp got id=%0d p=%h err=%b lat=%0d want id=%0d p=%h err=0 lat=3", rsp_id, rsp_product, rsp_err, lat, e[9:8], e[7:0]); end
      if (!rsp_ready) repeat ($urandom_range(1, 4)) @(posedge clk);
      finish_rsp();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    fault_inj = '0;
    test_reset();
    test_single();
    test_fairness();
    test_persistent_fault();
    test_transient_fault();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult4u_arb_ctrl.md
# mult4u_arb_ctrl

Sequencing and arbitration controller that shares one combinational 4x4 unsigned multiplier core between several requesters. It registers operands and registers the product. It checks every result with a mod-3 residue code and retries on mismatch, so faults escaping the gate-level core become detectable errors instead of silent ones. It sits between requesting datapath clients and any pareto variant of the 4-bit unsigned multiplier.

## Interface
- NUM_REQ, 2, number of requesters (2..4).
- MAX_RETRY, 2, re-executions allowed after a residue mismatch (0..7).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  4*NUM_REQ  operand A; requester i uses bits [4i+3:4i].
- req_b  in  4*NUM_REQ  operand B; same packing.
- req_ready  out  NUM_REQ  one-hot grant/accept; a request is accepted on an edge where valid&ready.
- rsp_valid  out  1  response available.
- rsp_id  out  2  index of the requester being answered.
- rsp_product  out  8  A*B, or the last computed value when rsp_err=1.
- rsp_err  out  1  residue check failed on every attempt.
- rsp_ready  in  1  consumer accepts the response.
- fault_inj  in  8  XOR mask applied to the core output, for test only; tie to 0 in product use.
- err_cnt  out  8  saturating count of responses with rsp_err=1.

## Operation
- FSM states: IDLE, ISSUE, CHECK, RESP.
- IDLE
  - Round-robin winner = first valid requester at or after rr_ptr, scanning in increasing index with wrap.
  - req_ready is driven combinationally for the winner only. It is 0 in all other states.
  - On acceptance, latch a, b and id, clear the attempt counter, and go to ISSUE.
- ISSUE
  - Latched operands drive the core.
  - The product register loads core_out ^ fault_inj at the end of the cycle. Go to CHECK.
- CHECK
  - Compare r8(product) with (r4(a)*r4(b)) mod 3, where r4 and r8 are the mod-3 residues.
  - Match: go to RESP with err=0.
  - Mismatch with attempts < MAX_RETRY: increment attempts, go to ISSUE.
  - Mismatch with attempts = MAX_RETRY: go to RESP with err=1.
- RESP
  - rsp_valid=1. rsp_id, rsp_product and rsp_err are held stable until rsp_ready.
  - On the handshake, go to IDLE, set rr_ptr = id+1 (mod NUM_REQ), and increment err_cnt if err=1, saturating at 255.
- Errors whose magnitude is a multiple of 3 are undetectable by design. This is a documented limitation, not a bug.
- rsp_id is zero-extended when NUM_REQ < 4.

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr 0, err_cnt 0, data registers 0.
- Latency, no retry: acceptance edge at cycle 0, ISSUE in cycle 1, CHECK in cycle 2, rsp_valid high from cycle 3.
- Each retry adds 2 cycles. Worst case is 3+2*MAX_RETRY cycles.
- Throughput: at most one operation in flight. A new request can be accepted at the earliest in the cycle after the response handshake.
- Requests that change while not ready are ignored. A requester must hold valid and data stable until ready.
- Simultaneous valid requests: exactly one is granted per IDLE visit. A continuously requesting client waits at most NUM_REQ-1 operations.
- rsp_ready held low: the FSM stays in RESP indefinitely, with outputs stable and no further grants.
- rst asserted in any state: the in-flight operation is dropped with no response, and the FSM is in IDLE in the next cycle.
- fault_inj is sampled only during ISSUE cycles.

## Structure
- Package mult4u_ctrl_pkg:
  - state enum;
  - width constants OPW=4, PW=8;
  - functions res3_4(4b) and res3_8(8b) returning 2-bit residues;
  - residue-multiply function.
- Sub-module mult4u_core: ports a[3:0], b[3:0], p[7:0]. It wraps whichever gate-level 4-bit unsigned multiplier variant is selected; its pin order is A[3:0], B[3:0], O[7:0].
- The controller itself contains the FSM, round-robin pointer, operand, product, attempt and err_cnt registers, and the residue checker.

## Test plan
- Single request: req0 with a=3, b=5, rsp_ready=1, fault_inj=0 -> rsp_valid in cycle 3 with product=0x0F, id=0, err=0.
- Fairness: both requesters continuously valid (a=15, b=15 and a=2, b=7) -> responses alternate id 0,1,0,1 with products 0xE1 and 0x0E.
- Persistent fault: fault_inj=0x01, a=3, b=5, MAX_RETRY=2 -> 3 attempts, rsp_valid at cycle 7, product=0x0E, err=1, err_cnt increments to 1.
- Transient fault: fault_inj=0x01 during the first ISSUE only -> one retry, rsp_valid at cycle 5, product=0x0F, err=0.
- Backpressure: rsp_ready=0 for 10 cycles with req1 pending -> response held stable, req_ready stays 0. When rsp_ready rises, req1 is granted the next cycle.
- Reset mid-operation: rst pulsed during CHECK -> no rsp_valid, all outputs 0, and a fresh request completes normally.
